// File: rtl/cxu_initiator_if.sv
// CXU initiator bundle: core request/result channel plus the cmd/rsp channel toward a CXU.
// The master side is the initiator; the slave side is the core and the responder it talks to.
interface cxu_initiator_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_function_id;
   logic [31:0] req_inputs_0;
   logic [31:0] req_inputs_1;
   logic [2:0]  req_state_id;
   logic [3:0]  req_cxu_id;

   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_error;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;
   logic [2:0]  cmd_payload_state_id;
   logic [3:0]  cmd_payload_cxu_id;
   logic        cmd_payload_ready;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;
   logic        rsp_payload_ready;

   modport master (
      input  req_valid, req_function_id, req_inputs_0, req_inputs_1, req_state_id, req_cxu_id,
      input  res_ready, cmd_ready, rsp_valid, rsp_payload_outputs_0, rsp_payload_ready,
      output req_ready, res_valid, res_data, res_error, cmd_valid,
      output cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
      output cmd_payload_state_id, cmd_payload_cxu_id, cmd_payload_ready, rsp_ready
   );

   modport slave (
      output req_valid, req_function_id, req_inputs_0, req_inputs_1, req_state_id, req_cxu_id,
      output res_ready, cmd_ready, rsp_valid, rsp_payload_outputs_0, rsp_payload_ready,
      input  req_ready, res_valid, res_data, res_error, cmd_valid,
      input  cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
      input  cmd_payload_state_id, cmd_payload_cxu_id, cmd_payload_ready, rsp_ready
   );
endinterface

// File: rtl/cxu_initiator.sv
// CPU-side CXU initiator: one custom-instruction request at a time, cmd/rsp exchange with a
// CXU, result or timeout error back to the core. All handshake outputs come from registers.
module cxu_initiator #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic            clk,
   input logic            reset,
   cxu_initiator_if.master bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      state;
   logic [15:0] count;
   logic        rsp_rdy;
   logic        expired;
   logic        unused_rsp_payload_ready;

   assign expired               = (count == 16'(TIMEOUT - 1));
   assign bus.rsp_ready         = rsp_rdy;
   assign bus.cmd_payload_ready = rsp_rdy;
   assign unused_rsp_payload_ready = bus.rsp_payload_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                       <= IDLE;
         count                       <= '0;
         bus.req_ready               <= 1'b1;
         bus.cmd_valid               <= 1'b0;
         rsp_rdy                     <= 1'b0;
         bus.res_valid               <= 1'b0;
         bus.res_error               <= 1'b0;
         bus.res_data                <= '0;
         bus.cmd_payload_function_id <= '0;
         bus.cmd_payload_inputs_0    <= '0;
         bus.cmd_payload_inputs_1    <= '0;
         bus.cmd_payload_state_id    <= '0;
         bus.cmd_payload_cxu_id      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  bus.cmd_payload_function_id <= bus.req_function_id;
                  bus.cmd_payload_inputs_0    <= bus.req_inputs_0;
                  bus.cmd_payload_inputs_1    <= bus.req_inputs_1;
                  bus.cmd_payload_state_id    <= bus.req_state_id;
                  bus.cmd_payload_cxu_id      <= bus.req_cxu_id;
                  count                       <= '0;
                  state                       <= ISSUE;
                  bus.req_ready               <= 1'b0;
                  bus.cmd_valid               <= 1'b1;
                  rsp_rdy                     <= 1'b1;
               end
            end
            ISSUE, WAIT: begin
               count <= count + 16'd1;
               // A reply only completes in ISSUE together with cmd fire; alone it is spurious.
               // Completion is tested before expiry so a reply on the last cycle still wins.
               if (bus.rsp_valid && (state == WAIT || bus.cmd_ready)) begin
                  state         <= DONE;
                  bus.cmd_valid <= 1'b0;
                  rsp_rdy       <= 1'b0;
                  bus.res_valid <= 1'b1;
                  bus.res_data  <= bus.rsp_payload_outputs_0;
                  bus.res_error <= 1'b0;
               end else if (expired) begin
                  state         <= DONE;
                  bus.cmd_valid <= 1'b0;
                  rsp_rdy       <= 1'b0;
                  bus.res_valid <= 1'b1;
                  bus.res_data  <= '0;
                  bus.res_error <= 1'b1;
               end else if (state == ISSUE && bus.cmd_ready) begin
                  state         <= WAIT;
                  bus.cmd_valid <= 1'b0;
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  state         <= IDLE;
                  bus.res_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cxu_initiator.sv
// Bench for cxu_initiator: directed plan cases plus randomized responder timing, checked against
// a latency/result model derived from command-accept cycle, reply delay and the timeout limit.
module tb_cxu_initiator;
   localparam int unsigned TO = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   cxu_initiator_if bus();

   cxu_initiator #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mulres(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] p;
      logic signed [63:0] q;
      p = $signed(a) * $signed(b);
      q = p >>> 10;
      return (f == 3'd1) ? p[31:0] : q[31:0];
   endfunction

   task automatic junk();
      bus.cmd_ready             = 1'($urandom_range(0, 1));
      bus.rsp_valid             = 1'($urandom_range(0, 1));
      bus.rsp_payload_outputs_0 = $urandom();
      bus.rsp_payload_ready     = 1'($urandom_range(0, 1));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, bus.req_ready, 1);
      chk({tag, "_cmd_valid"}, bus.cmd_valid, 0);
      chk({tag, "_rsp_ready"}, bus.rsp_ready, 0);
      chk({tag, "_cmd_payload_ready"}, bus.cmd_payload_ready, 0);
      chk({tag, "_res_valid"}, bus.res_valid, 0);
      chk({tag, "_res_error"}, bus.res_error, 0);
      chk({tag, "_res_data"}, bus.res_data, 0);
      chk({tag, "_func"}, bus.cmd_payload_function_id, 0);
      chk({tag, "_in0"}, bus.cmd_payload_inputs_0, 0);
      chk({tag, "_in1"}, bus.cmd_payload_inputs_1, 0);
      chk({tag, "_sid"}, bus.cmd_payload_state_id, 0);
      chk({tag, "_cid"}, bus.cmd_payload_cxu_id, 0);
   endtask

   // Starts and ends at a negedge with the DUT in IDLE. cmd_lat: ISSUE cycles with cmd_ready low
   // before it rises; k: reply delay in cycles after the command is accepted.
   task automatic txn(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] sid, input logic [3:0] cid,
                      input int cmd_lat, input int k, input logic [31:0] data,
                      input bit spur, input int hold);
      bit          ok;
      int          done_t;
      logic [31:0] exp_data;
      ok       = (cmd_lat + k <= int'(TO) - 1);
      done_t   = ok ? cmd_lat + k + 1 : int'(TO);
      exp_data = ok ? data : 32'd0;

      bus.req_function_id = f;
      bus.req_inputs_0    = a;
      bus.req_inputs_1    = b;
      bus.req_state_id    = sid;
      bus.req_cxu_id      = cid;
      bus.req_valid       = 1'b1;
      chk({tag, "_req_ready_idle"}, bus.req_ready, 1);
      @(posedge clk); #1;
      bus.req_valid       = 1'b0;
      bus.req_function_id = 3'($urandom());
      bus.req_inputs_0    = $urandom();
      bus.req_inputs_1    = $urandom();
      bus.req_state_id    = 3'($urandom());
      bus.req_cxu_id      = 4'($urandom());

      for (int t = 0; t <= done_t; t++) begin
         if (t < done_t) begin
            bus.cmd_ready = (t >= cmd_lat);
            bus.rsp_valid = (t == cmd_lat + k) ||
                            (spur && t < cmd_lat && $urandom_range(0, 1) == 1);
            bus.rsp_payload_outputs_0 = (t == cmd_lat + k) ? data : $urandom();
         end else begin
            junk();
         end
         @(negedge clk);
         chk({tag, "_cmd_valid"}, bus.cmd_valid, (t <= cmd_lat) && (t < done_t));
         chk({tag, "_rsp_ready"}, bus.rsp_ready, t < done_t);
         chk({tag, "_cmd_payload_ready"}, bus.cmd_payload_ready, t < done_t);
         chk({tag, "_res_valid"}, bus.res_valid, t == done_t);
         chk({tag, "_req_ready_busy"}, bus.req_ready, 0);
         if (t < done_t) begin
            @(posedge clk); #1;
         end
      end

      chk({tag, "_res_data"}, bus.res_data, exp_data);
      chk({tag, "_res_error"}, bus.res_error, !ok);
      chk({tag, "_func"}, bus.cmd_payload_function_id, f);
      chk({tag, "_in0"}, bus.cmd_payload_inputs_0, a);
      chk({tag, "_in1"}, bus.cmd_payload_inputs_1, b);
      chk({tag, "_sid"}, bus.cmd_payload_state_id, sid);
      chk({tag, "_cid"}, bus.cmd_payload_cxu_id, cid);

      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         junk();
         bus.req_valid    = 1'b1;
         bus.req_inputs_0 = $urandom();
         @(negedge clk);
         chk({tag, "_hold_res_valid"}, bus.res_valid, 1);
         chk({tag, "_hold_res_data"}, bus.res_data, exp_data);
         chk({tag, "_hold_res_error"}, bus.res_error, !ok);
         chk({tag, "_hold_req_ready"}, bus.req_ready, 0);
         chk({tag, "_hold_cmd_valid"}, bus.cmd_valid, 0);
         chk({tag, "_hold_in0"}, bus.cmd_payload_inputs_0, a);
      end

      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_pre_release_res_valid"}, bus.res_valid, 1);
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      bus.req_valid = 1'b0;
      bus.cmd_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_post_res_valid"}, bus.res_valid, 0);
      chk({tag, "_post_req_ready"}, bus.req_ready, 1);
      chk({tag, "_post_cmd_valid"}, bus.cmd_valid, 0);
   endtask

   // Reset asserted mid-cycle at ISSUE-relative cycle at_t; ends at a negedge in IDLE.
   task automatic reset_mid(input string tag, input int at_t, input int cmd_lat);
      bus.req_function_id = 3'($urandom());
      bus.req_inputs_0    = $urandom() | 32'h1;
      bus.req_inputs_1    = $urandom();
      bus.req_state_id    = 3'd5;
      bus.req_cxu_id      = 4'hC;
      bus.req_valid       = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      for (int t = 0; t < at_t; t++) begin
         bus.cmd_ready = (t >= cmd_lat);
         bus.rsp_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.cmd_ready = (at_t >= cmd_lat);
      bus.rsp_valid = 1'b0;
      #2;
      chk({tag, "_pre_rsp_ready"}, bus.rsp_ready, 1);
      chk({tag, "_pre_cmd_valid"}, bus.cmd_valid, at_t <= cmd_lat);
      reset = 1'b1;
      #1;
      chk_reset_vals(tag);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      bus.cmd_ready             = 1'b1;
      bus.rsp_valid             = 1'b1;
      bus.rsp_payload_outputs_0 = $urandom();
      @(negedge clk);
      chk({tag, "_stale_res_valid"}, bus.res_valid, 0);
      chk({tag, "_stale_req_ready"}, bus.req_ready, 1);
      chk({tag, "_stale_cmd_valid"}, bus.cmd_valid, 0);
      @(posedge clk); #1;
      bus.cmd_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_stale2_res_valid"}, bus.res_valid, 0);
      chk({tag, "_stale2_res_data"}, bus.res_data, 0);
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      int          cl;
      int          kk;

      bus.req_valid             = 1'b0;
      bus.req_function_id       = '0;
      bus.req_inputs_0          = '0;
      bus.req_inputs_1          = '0;
      bus.req_state_id          = '0;
      bus.req_cxu_id            = '0;
      bus.res_ready             = 1'b0;
      bus.cmd_ready             = 1'b0;
      bus.rsp_valid             = 1'b0;
      bus.rsp_payload_outputs_0 = '0;
      bus.rsp_payload_ready     = 1'b0;

      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b0;

      txn("mul", 3'd1, 32'd3, 32'd5, 3'd1, 4'd2, 0, 0, 32'd15, 1'b0, 0);
      txn("shmul", 3'd0, 32'd2048, 32'd1024, 3'd2, 4'd3, 0, 0, 32'd2048, 1'b0, 1);
      txn("shmul_neg", 3'd0, 32'hFFFF_F000, 32'd3, 3'd3, 4'd1, 0, 0, 32'hFFFF_FFF4, 1'b0, 0);
      txn("delayed", 3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 3'd5, 4'hA, 0, 4, 32'hDEAD_BEEF,
          1'b0, 2);
      txn("timeout", 3'd4, 32'h1, 32'h2, 3'd6, 4'h7, 100, 0, 32'h5555_5555, 1'b1, 0);
      txn("expiry_wait", 3'd1, 32'h11, 32'h22, 3'd0, 4'h4, 0, 7, 32'hCAFE_F00D, 1'b0, 0);
      txn("expiry_issue", 3'd1, 32'h33, 32'h44, 3'd1, 4'h5, 7, 0, 32'h0BAD_CAFE, 1'b1, 0);
      txn("timeout_after_fire", 3'd3, 32'h55, 32'h66, 3'd2, 4'h6, 7, 1, 32'h7777_7777, 1'b0, 0);
      txn("timeout_wait", 3'd3, 32'h77, 32'h88, 3'd4, 4'h8, 3, 5, 32'h8888_8888, 1'b1, 0);
      txn("backpressure", 3'd1, 32'd7, 32'd9, 3'd7, 4'hF, 1, 2, 32'd63, 1'b1, 10);
      txn("back_to_back", 3'd0, 32'd4096, 32'd4096, 3'd1, 4'h9, 0, 0, 32'd16384, 1'b0, 0);

      reset_mid("reset_wait", 2, 0);
      reset_mid("reset_issue", 1, 5);
      txn("after_reset", 3'd1, 32'd6, 32'd7, 3'd2, 4'h3, 0, 0, 32'd42, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         f  = 3'($urandom_range(0, 1));
         a  = $urandom();
         b  = $urandom();
         cl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 3));
         kk = int'($urandom_range(0, 8));
         txn("rand", f, a, b, 3'($urandom()), 4'($urandom()), cl, kk, mulres(f, a, b),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cxu_initiator.md
# cxu_initiator

CPU-side initiator for the CXU command/response interface. It accepts one custom-instruction request at a time from the core pipeline, drives the `cmd_*` channel toward a CXU, collects the `rsp_*` reply, and returns the 32-bit result, or a timeout error, to the core. It sits between the core's custom-instruction issue stage and any CXU responder, and tolerates both combinational (same-cycle) and multi-cycle responders.

## Interface
- `TIMEOUT`, default 255: cycles spent in ISSUE+WAIT before the transaction is aborted with an error. Legal range 1..65535.
- `clk`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  core request valid
- `req_ready`  out  1  high only in IDLE
- `req_function_id`  in  3  captured into the command
- `req_inputs_0`, `req_inputs_1`  in  32 each  captured operands
- `req_state_id`  in  3  captured state id
- `req_cxu_id`  in  4  captured target CXU id
- `res_valid`  out  1  result valid (DONE state)
- `res_ready`  in  1  core accepts result
- `res_data`  out  32  CXU output, or 0 on error
- `res_error`  out  1  1 = timeout abort
- `cmd_valid`  out  1  high only in ISSUE
- `cmd_ready`  in  1  responder accepts command
- `cmd_payload_function_id` out 3, `cmd_payload_inputs_0` out 32, `cmd_payload_inputs_1` out 32, `cmd_payload_state_id` out 3, `cmd_payload_cxu_id` out 4: registered copies of the request
- `cmd_payload_ready`  out  1  equals `rsp_ready`
- `rsp_valid`  in  1  responder reply valid
- `rsp_ready`  out  1  high in ISSUE and WAIT
- `rsp_payload_outputs_0`  in  32  reply data
- `rsp_payload_ready`  in  1  ignored

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, register all request fields, clear the timeout counter, and go to ISSUE.
- **ISSUE:**
  - `cmd_valid`=1, `rsp_ready`=1.
  - cmd fire and rsp fire in the same cycle: capture `rsp_payload_outputs_0` into `res_data`, set `res_error`=0, go to DONE.
  - cmd fire only: go to WAIT.
  - `rsp_valid` without cmd fire is spurious: ignore it and stay in ISSUE.
- **WAIT:**
  - `cmd_valid`=0, `rsp_ready`=1.
  - On `rsp_valid`, capture data, set `res_error`=0, go to DONE.
- **Timeout:**
  - Counter increments each cycle spent in ISSUE or WAIT.
  - When the counter reaches TIMEOUT-1 and no completing fire occurs that cycle, go to DONE with `res_data`=0 and `res_error`=1.
  - `cmd_valid` drops in the same transition, so no command is left dangling.
  - A completing fire on the expiry cycle wins over the timeout.
- **DONE:**
  - `res_valid`=1.
  - On `res_ready`, go to IDLE.
  - `res_data` and `res_error` hold stable until accepted.
- **No combinational paths:**
  - `cmd_valid`, `rsp_ready` and `cmd_payload_ready` are decoded from state only, never from `cmd_ready` or `rsp_valid`.
  - This is mandatory because responders may tie `rsp_valid` to `cmd_valid` and `cmd_ready` to `rsp_ready`.
- **Payload stability:** `cmd_payload_*` are held stable from entry to ISSUE until the next request is captured.
- **Reset values (asynchronous):**
  - State IDLE.
  - `req_ready`=1; `cmd_valid`=0, `rsp_ready`=0, `res_valid`=0, `res_error`=0.
  - `res_data`=0, all `cmd_payload_*`=0, counter 0.
- **Reset mid-transaction:** abandons the transaction immediately. No result is produced and `cmd_valid` drops asynchronously.

## Timing
- Request accepted at edge N (IDLE).
- ISSUE during cycle N+1.
- With a same-cycle responder, DONE during N+2, i.e. `res_valid` two cycles after the `req_valid`/`req_ready` handshake.
- With a responder that replies k cycles after the cmd fire: `res_valid` asserts k cycles after the N+2 (same-cycle) case.
- Timeout with `cmd_ready` held low: `res_valid`/`res_error` assert exactly TIMEOUT cycles after ISSUE entry.
- Throughput: at most one transaction per 3 cycles. The next request is accepted at the earliest in the cycle after `res_ready` fires (IDLE).
- `res_ready` held low keeps DONE indefinitely. No new `cmd_valid` is issued meanwhile.

## Test plan
- **Multiply, function_id 1:** combinational multiply responder (function_id 1 → product, 0 → product >>> 10), request inputs 3, 5, function_id 1. Expect `cmd_valid` for one cycle, then `res_data`=15, `res_error`=0, `res_valid` 2 cycles after request acceptance.
- **Shifted multiply:** same responder, inputs 2048, 1024, function_id 0 → `res_data`=2048. Inputs −4096 (0xFFFFF000), 3, function_id 0 → `res_data`=0xFFFFFFF4.
- **Delayed responder:** `cmd_ready`=1, `rsp_valid` 4 cycles after the cmd fire, data 0xDEADBEEF. Expect a WAIT dwell of 4 cycles, `rsp_ready` high throughout, `res_data`=0xDEADBEEF. Also check that `cmd_payload_*` match the captured request (cxu_id 0xA, state_id 5).
- **Timeout:** TIMEOUT=8, `cmd_ready` held 0. Expect `res_valid`=1, `res_error`=1, `res_data`=0 at 8 cycles after ISSUE entry, and `cmd_valid` low from then on. Repeat with `rsp_valid` firing exactly on the expiry cycle → success, not error.
- **Result backpressure:** hold `res_ready`=0 for 10 cycles in DONE. Expect `res_data` stable, `req_ready`=0, no `cmd_valid`. Then release and issue a back-to-back request, which is accepted the cycle after the release.
- **Reset mid-transaction:** assert `reset` during WAIT. Expect all outputs at their reset values immediately (asynchronously), `req_ready`=1 after reset deasserts, and a stale `rsp_valid` arriving afterwards ignored.
